// File: rtl/hazard_unit.sv
`timescale 1ns/1ps
// hazard_unit
//   Central stall / bubble / flush / halt controller for the 5-stage pipeline.
//   Produces the latch enables and flushes for the F/D, D/E, E/M and M/W
//   latches plus the PC update enable. A flush loads a NOP control word when
//   that latch's enable is high.
//
// Ports
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   ihit, dhit           fetch valid / data access complete this cycle
//   dREN_mem, dWEN_mem   memory-stage load / store request
//   dREN_ex, wsel_ex     execute-stage load flag and destination register
//   rs_dec, rt_dec,
//   use_rt_dec           decode-stage source registers
//   branch_taken_mem,
//   jump_mem             control redirect resolved in memory stage
//   halt_wb              halt reached writeback
//   pc_en, en_*, flush_* latch / PC controls (combinational)
//   halted               sticky halt indication
//   stall_cnt            cycles with pc_en=0 outside HALT
//
// Build option
//   HAZARD_STALL_CNT_EN  enables the saturating stall counter; when undefined
//                        stall_cnt is tied to zero.
module hazard_unit #(
   parameter int STALL_CNT_W   = 16,
   parameter int REDIRECT_HOLD = 0
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic                   dREN_mem,
   input  logic                   dWEN_mem,
   input  logic                   dREN_ex,
   input  logic [4:0]             wsel_ex,
   input  logic [4:0]             rs_dec,
   input  logic [4:0]             rt_dec,
   input  logic                   use_rt_dec,
   input  logic                   branch_taken_mem,
   input  logic                   jump_mem,
   input  logic                   halt_wb,
   output logic                   pc_en,
   output logic                   en_fd,
   output logic                   en_de,
   output logic                   en_em,
   output logic                   en_mw,
   output logic                   flush_fd,
   output logic                   flush_de,
   output logic                   flush_em,
   output logic                   flush_mw,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DWAIT = 2'd1;
   localparam logic [1:0] ST_REDIR = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [1:0] HOLD_INIT = 2'(REDIRECT_HOLD);

   logic [1:0] state, state_nxt;
   logic [1:0] hold, hold_nxt;
   logic       mem_pend, redirect, load_use, eval_run;

   // en/flush bundles ordered {fd, de, em, mw}
   logic [3:0] en, flush;

   assign mem_pend = (dREN_mem | dWEN_mem) & ~dhit;
   assign redirect = branch_taken_mem | jump_mem;
   assign load_use = dREN_ex & (wsel_ex != 5'd0) &
                     ((wsel_ex == rs_dec) | (use_rt_dec & (wsel_ex == rt_dec)));

   always_comb begin
      pc_en     = 1'b1;
      en        = 4'b1111;
      flush     = 4'b0000;
      state_nxt = state;
      hold_nxt  = hold;
      eval_run  = 1'b0;

      case (state)
         ST_HALT: begin
            pc_en = 1'b0;
            en    = 4'b0000;
         end
         ST_DWAIT: begin
            if (!dhit) begin
               pc_en = 1'b0;
               en    = 4'b0000;
               if (halt_wb) state_nxt = ST_HALT;
            end else begin
               eval_run = 1'b1;
            end
         end
         ST_REDIR: begin
            if (halt_wb) begin
               eval_run = 1'b1;
            end else if (mem_pend) begin
               // freeze in place; stay in REDIR with the hold count intact
               pc_en = 1'b0;
               en    = 4'b0000;
            end else if (redirect) begin
               eval_run = 1'b1;
            end else begin
               // fetch bubble; decode already holds a NOP so load-use is moot
               pc_en    = 1'b0;
               flush[3] = 1'b1;
               hold_nxt = hold - 2'd1;
               if (hold <= 2'd1) begin
                  state_nxt = ST_RUN;
                  hold_nxt  = 2'd0;
               end
            end
         end
         default: eval_run = 1'b1;
      endcase

      if (eval_run) begin
         state_nxt = ST_RUN;
         if (halt_wb) begin
            pc_en     = 1'b0;
            en        = 4'b0000;
            state_nxt = ST_HALT;
         end else if (mem_pend) begin
            pc_en     = 1'b0;
            en        = 4'b0000;
            state_nxt = ST_DWAIT;
         end else if (redirect) begin
            flush = 4'b1110;
            if (REDIRECT_HOLD > 0) begin
               state_nxt = ST_REDIR;
               hold_nxt  = HOLD_INIT;
            end
         end else if (load_use) begin
            pc_en    = 1'b0;
            en[3]    = 1'b0;
            flush[2] = 1'b1;
         end else if (!ihit) begin
            pc_en    = 1'b0;
            flush[3] = 1'b1;
         end
      end

      if (!nRST) begin
         pc_en = 1'b0;
         en    = 4'b0000;
         flush = 4'b1111;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= ST_RUN;
         hold  <= 2'd0;
      end else begin
         state <= state_nxt;
         hold  <= hold_nxt;
      end
   end

   assign {en_fd, en_de, en_em, en_mw}         = en;
   assign {flush_fd, flush_de, flush_em, flush_mw} = flush;
   assign halted = nRST & (state == ST_HALT);

`ifdef HAZARD_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] cnt;
   always_ff @(posedge CLK) begin
      if (!nRST)
         cnt <= '0;
      else if (!pc_en && (state != ST_HALT) && (cnt != '1))
         cnt <= cnt + 1'b1;
   end
   assign stall_cnt = cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
`timescale 1ns/1ps
module tb_hazard_unit;

   localparam int HOLD = 2;
   localparam int CW   = 16;

   logic CLK = 1'b0;
   logic nRST, ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, use_rt_dec;
   logic branch_taken_mem, jump_mem, halt_wb;
   logic [4:0] wsel_ex, rs_dec, rt_dec;
   logic pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw, halted;
   logic [CW-1:0] stall_cnt;

   always #5 CLK = ~CLK;

   hazard_unit #(.STALL_CNT_W(CW), .REDIRECT_HOLD(HOLD)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
      .wsel_ex(wsel_ex), .rs_dec(rs_dec), .rt_dec(rt_dec), .use_rt_dec(use_rt_dec),
      .branch_taken_mem(branch_taken_mem), .jump_mem(jump_mem), .halt_wb(halt_wb),
      .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
      .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mw(flush_mw),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      bit nrst, ihit, dhit, dren_mem, dwen_mem, dren_ex;
      bit [4:0] wsel, rs, rt;
      bit use_rt, br, jmp, halt;
   } stim_t;

   typedef struct packed {
      bit [9:0]    ctl;   // {pc_en, en fd/de/em/mw, flush fd/de/em/mw, halted}
      bit [CW-1:0] cnt;
   } exp_t;

   // expected control words by pipeline action
   localparam bit [9:0] C_RST    = 10'b0_0000_1111_0;
   localparam bit [9:0] C_FREEZE = 10'b0_0000_0000_0;
   localparam bit [9:0] C_HALTED = 10'b0_0000_0000_1;
   localparam bit [9:0] C_REDIR  = 10'b1_1111_1110_0;
   localparam bit [9:0] C_LU     = 10'b0_0111_0100_0;
   localparam bit [9:0] C_BUB    = 10'b0_1111_1000_0;
   localparam bit [9:0] C_RUN    = 10'b1_1111_0000_0;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: sticky flags and a remaining-bubble count
   bit m_halt, m_dwait;
   int m_hold, m_cnt;

   task automatic model(input stim_t s, output exp_t e);
      bit mp, rd, lu, was_halt;
      mp = (s.dren_mem || s.dwen_mem) && !s.dhit;
      rd = s.br || s.jmp;
      lu = s.dren_ex && (s.wsel != 0) && (s.wsel == s.rs || (s.use_rt && s.wsel == s.rt));
`ifdef HAZARD_STALL_CNT_EN
      e.cnt = CW'(m_cnt);
`else
      e.cnt = '0;
`endif
      if (!s.nrst) begin
         e.ctl = C_RST;
         m_halt = 0; m_dwait = 0; m_hold = 0; m_cnt = 0;
         return;
      end
      was_halt = m_halt;
      if (m_halt) e.ctl = C_HALTED;
      else if (s.halt) begin e.ctl = C_FREEZE; m_halt = 1; end
      else if (m_dwait && !s.dhit) e.ctl = C_FREEZE;
      else if (m_hold > 0) begin
         if (mp) e.ctl = C_FREEZE;
         else if (rd) begin e.ctl = C_REDIR; m_hold = HOLD; end
         else begin e.ctl = C_BUB; m_hold--; end
      end else begin
         m_dwait = 0;
         if (mp) begin e.ctl = C_FREEZE; m_dwait = 1; end
         else if (rd) begin e.ctl = C_REDIR; m_hold = HOLD; end
         else if (lu) e.ctl = C_LU;
         else if (!s.ihit) e.ctl = C_BUB;
         else e.ctl = C_RUN;
      end
      if (!was_halt && !e.ctl[9] && m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      s.nrst = 1; s.ihit = 1; s.dhit = 1;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.nrst     = ($urandom % 64) != 0;
      s.ihit     = ($urandom % 4) != 0;
      s.dhit     = ($urandom % 2) != 0;
      s.dren_mem = ($urandom % 4) == 0;
      s.dwen_mem = ($urandom % 8) == 0;
      s.dren_ex  = ($urandom % 2) != 0;
      s.wsel     = 5'($urandom_range(0, 7));
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.use_rt   = ($urandom % 2) != 0;
      s.br       = ($urandom % 10) == 0;
      s.jmp      = ($urandom % 16) == 0;
      s.halt     = ($urandom % 150) == 0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      nRST = s.nrst; ihit = s.ihit; dhit = s.dhit;
      dREN_mem = s.dren_mem; dWEN_mem = s.dwen_mem; dREN_ex = s.dren_ex;
      wsel_ex = s.wsel; rs_dec = s.rs; rt_dec = s.rt; use_rt_dec = s.use_rt;
      branch_taken_mem = s.br; jump_mem = s.jmp; halt_wb = s.halt;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      drive(s);
      model(s, e);
      expq.push_back(e);
      @(posedge CLK); #1;
   endtask

   // monitor: outputs are valid every cycle, compare mid-cycle
   always @(negedge CLK) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if ({pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw, halted} !== e.ctl) begin
            errors++;
            $display("FAIL ctl t=%0t act=%b exp=%b", $time,
                     {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw, halted}, e.ctl);
         end
         checks++;
         if (stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL stall_cnt t=%0t act=%0d exp=%0d", $time, stall_cnt, e.cnt);
         end
      end
   end

   initial begin
      stim_t s;
      drive(idle());
      nRST = 0;
      m_halt = 0; m_dwait = 0; m_hold = 0; m_cnt = 0;
      @(posedge CLK); #1;

      s = idle(); s.nrst = 0; step(s); step(s);
      step(idle()); step(idle());
      // load-use
      s = idle(); s.dren_ex = 1; s.wsel = 5; s.rs = 5; step(s);
      step(idle());
      // wsel_ex = 0 never stalls
      s = idle(); s.dren_ex = 1; s.wsel = 0; s.rs = 0; step(s);
      // load-use through rt
      s = idle(); s.dren_ex = 1; s.wsel = 7; s.rt = 7; s.use_rt = 1; step(s);
      // fetch miss
      s = idle(); s.ihit = 0; step(s);
      // data stall 3 cycles
      s = idle(); s.dren_mem = 1; s.dhit = 0; step(s); step(s); step(s);
      s.dhit = 1; step(s);
      step(idle());
      // redirect with load-use, then hold bubbles
      s = idle(); s.br = 1; s.dren_ex = 1; s.wsel = 3; s.rs = 3; step(s);
      step(idle()); step(idle()); step(idle());
      // redirect with fetch miss
      s = idle(); s.jmp = 1; s.ihit = 0; step(s);
      // memory freeze inside REDIR, then release
      s = idle(); s.dwen_mem = 1; s.dhit = 0; step(s); step(s);
      step(idle()); step(idle());
      // reset mid-DWAIT
      s = idle(); s.dren_mem = 1; s.dhit = 0; step(s); step(s);
      s.nrst = 0; step(s);
      step(idle());
      // halt with fetch miss, then 10 cycles of noise
      s = idle(); s.halt = 1; s.ihit = 0; step(s);
      for (int i = 0; i < 10; i++) begin
         s = rnd(); s.nrst = 1; step(s);
      end
      s = idle(); s.nrst = 0; step(s);
      // random traffic
      for (int i = 0; i < 3000; i++) step(rnd());

      @(negedge CLK); #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL queue_drain act=%0d exp=0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Generates the latch enables, latch flushes and PC enable that drive the pipeline latch interface: en_fd/en_de/en_em/en_mw, flush_fd/flush_de/flush_em/flush_mw and pc_en.
- Owns every stall, bubble, redirect-flush and halt decision for the 5-stage datapath.
- Takes hit, hazard and control status from the fetch, decode, execute, memory and writeback stages.

Parameters:
- STALL_CNT_W, 16: width of the stall-cycle counter (only used with HAZARD_STALL_CNT_EN).
- REDIRECT_HOLD, 0: extra fetch-bubble cycles after a redirect, range 0..3.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction fetch valid this cycle.
- dhit  in  1  data access complete this cycle.
- dREN_mem  in  1  memory-stage load request.
- dWEN_mem  in  1  memory-stage store request.
- dREN_ex  in  1  execute-stage instruction is a load.
- wsel_ex  in  5  execute-stage destination register.
- rs_dec  in  5  decode-stage rs.
- rt_dec  in  5  decode-stage rt.
- use_rt_dec  in  1  decode instruction reads rt.
- branch_taken_mem  in  1  resolved taken branch in memory stage.
- jump_mem  in  1  jump/jr/jal in memory stage.
- halt_wb  in  1  halt instruction reached writeback.
- pc_en  out  1  PC register update enable.
- en_fd, en_de, en_em, en_mw  out  1 each  latch enables.
- flush_fd, flush_de, flush_em, flush_mw  out  1 each  latch flushes; a flush loads a NOP/zero control word when that latch's enable is high.
- halted  out  1  sticky halt indication.
- stall_cnt  out  STALL_CNT_W  stall cycles counted (feature only).

Behaviour:
- Outputs are combinational from state plus inputs. State, hold counter and stall_cnt update on the rising edge of CLK.
- Reset (nRST=0 at the edge):
  - State goes to RUN, the hold counter to 0, halted to 0, stall_cnt to 0.
  - While nRST=0: all en_* = 0, all flush_* = 1, pc_en = 0, halted = 0.
- States:
  - RUN: normal operation.
  - DWAIT: data access outstanding.
  - REDIR: fetch hold after a redirect.
  - HALT: stopped.
- Default outputs in RUN with no event: all en_* = 1, all flush_* = 0, pc_en = 1.
- Priority in RUN, and in DWAIT/REDIR once their own condition is released:
  1. halt_wb: all en_* = 0, pc_en = 0; next state HALT.
  2. Memory pending, i.e. (dREN_mem | dWEN_mem) & !dhit: freeze with all en_* = 0, pc_en = 0, flushes 0; next state DWAIT.
  3. Redirect, i.e. branch_taken_mem | jump_mem:
     - All en_* = 1; flush_fd = flush_de = flush_em = 1; flush_mw = 0; pc_en = 1.
     - Next state REDIR with hold counter = REDIRECT_HOLD if REDIRECT_HOLD > 0, else RUN.
  4. Load-use, i.e. dREN_ex & wsel_ex != 0 & (wsel_ex == rs_dec | (use_rt_dec & wsel_ex == rt_dec)):
     - pc_en = 0, en_fd = 0; en_de = 1 with flush_de = 1 (bubble); en_em = en_mw = 1.
     - Lasts exactly one cycle, because the load then leaves execute.
  5. !ihit: pc_en = 0; en_fd = 1 with flush_fd = 1; downstream latches advance.
- A redirect in the same cycle as a load-use hazard: redirect wins.
- A redirect in the same cycle as !ihit: redirect wins, and the PC loads the target.
- DWAIT:
  - While !dhit: freeze; halt_wb is still honoured.
  - On dhit: evaluate the priority list above as in RUN, excluding item 2, and take its next state.
- REDIR:
  - Each cycle: pc_en = 0; en_fd = 1 with flush_fd = 1; other latches advance. The counter decrements; at 1 the next state is RUN.
  - A memory-pending freeze overrides and the counter holds. The freeze returns to REDIR, not RUN.
  - A new redirect reloads the counter.
- HALT: all en_* = 0, flush_* = 0, pc_en = 0, halted = 1. Exits only on reset.
- Reset during DWAIT or REDIR discards state immediately; no residual stall follows.
- wsel_ex = 0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- With the macro: stall_cnt increments by 1 on every cycle with pc_en = 0 and state != HALT. It saturates at all-ones and does not wrap.
- Without the macro: the counter logic is omitted and stall_cnt is tied to 0.

Test Plan:
- Load-use: dREN_ex = 1, wsel_ex = 5, rs_dec = 5, ihit = 1 -> one cycle with pc_en = 0, en_fd = 0, flush_de = 1, en_em = 1; next cycle all en_* = 1.
- Data stall: dREN_mem = 1, dhit = 0 for 3 cycles, then dhit = 1 -> all en_* = 0 for 3 cycles, then all en_* = 1; stall_cnt = 3 with the feature.
- Redirect and load-use together: branch_taken_mem = 1 with a load-use hazard -> flush_fd/de/em = 1, pc_en = 1, flush_mw = 0; with REDIRECT_HOLD = 2, the next 2 cycles have pc_en = 0, flush_fd = 1.
- Halt: halt_wb = 1 while ihit = 0 -> all en_* = 0, halted = 1 from the next cycle; halted stays 1 for 10 more cycles regardless of inputs.
- Reset: nRST = 0 mid-DWAIT -> during reset all flush_* = 1, en_* = 0; after release with dREN_mem = 0, ihit = 1, the first cycle has all en_* = 1, pc_en = 1, halted = 0.
- Fetch miss: ihit = 0, no hazards -> pc_en = 0, en_fd = 1, flush_fd = 1, en_de/en_em/en_mw = 1.
